// File: rtl/fwd_scoreboard_pkg.sv
// Shared definitions for the forwarding scoreboard: address width,
// select encodings and scoreboard-entry field widths.
package fwd_scoreboard_pkg;

  localparam int REG_ADDRESS_LEN = 4;
  localparam int FWD_NUM_SRC     = 3;
  localparam int FWD_DEPTH       = 3;
  localparam int FWD_ALU_READY   = 1;
  localparam int FWD_LOAD_READY  = 2;

  // Select encodings: 0 reads the register file, k+1 forwards from stage k.
  localparam int FORW_SEL_RF       = 0;
  localparam int FORW_SEL_FROM_MEM = 2;
  localparam int FORW_SEL_FROM_WB  = 3;

  // Scoreboard entry fields: {valid, wb_en, is_load, dst}.
  localparam int SB_VALID_W = 1;
  localparam int SB_WB_W    = 1;
  localparam int SB_LOAD_W  = 1;
  localparam int SB_DST_W   = REG_ADDRESS_LEN;
  localparam int SB_ENTRY_W = SB_VALID_W + SB_WB_W + SB_LOAD_W + SB_DST_W;

  function automatic int forw_sel_stage(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-source priority scan of the scoreboard: finds the youngest in-flight
// writer of this source and reports whether its result is forwardable yet.
module fwd_src_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDRESS_LEN,
  parameter int DEPTH      = FWD_DEPTH,
  parameter int ALU_READY  = FWD_ALU_READY,
  parameter int LOAD_READY = FWD_LOAD_READY,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                                used,
  input  logic [REG_ADDR_W-1:0]               src,
  input  logic [DEPTH-1:0]                    ent_vld,
  input  logic [DEPTH-1:0]                    ent_wb,
  input  logic [DEPTH-1:0]                    ent_ld,
  input  logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_dst,
  output logic                                hit,
  output logic [SEL_W-1:0]                    k,
  output logic                                ready,
  output logic                                early
);

  // Scan oldest to youngest so the lowest matching stage overwrites the rest;
  // early flags any match short of WB, used when forwarding is disabled.
  always_comb begin
    hit   = 1'b0;
    k     = '0;
    ready = 1'b0;
    early = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (used && ent_vld[j] && ent_wb[j] && ent_dst[j] == src) begin
        hit   = 1'b1;
        k     = SEL_W'(j);
        ready = ent_ld[j] ? (j >= LOAD_READY) : (j >= ALU_READY);
        if (j < DEPTH - 1) early = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: shift register of in-flight writers (EXE..WB),
// per-source forwarding selects, unified load-use/no-forward stall and a
// saturating stall-cycle counter.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDRESS_LEN,
  parameter int NUM_SRC    = FWD_NUM_SRC,
  parameter int DEPTH      = FWD_DEPTH,
  parameter int ALU_READY  = FWD_ALU_READY,
  parameter int LOAD_READY = FWD_LOAD_READY,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_forwarding,
  input  logic                          freeze,
  input  logic                          flush,
  input  logic                          id_valid,
  input  logic                          id_wb_en,
  input  logic                          id_is_load,
  input  logic [REG_ADDR_W-1:0]         id_dst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  output logic [NUM_SRC*SEL_W-1:0]      sel_src,
  output logic                          stall,
  output logic [31:0]                   stall_count
);

  logic [DEPTH-1:0]                 vld_q, vld_d, wb_q, wb_d, ld_q, ld_d;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] dst_q, dst_d;
  logic [31:0]                      cnt_q, cnt_d;

  logic [NUM_SRC-1:0]               hit, ready, early, stall_src;
  logic [NUM_SRC-1:0][SEL_W-1:0]    k, sel;

  fwd_src_match #(
    .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .ALU_READY(ALU_READY),
    .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
  ) u_match [NUM_SRC-1:0] (
    .used    (id_src_used),
    .src     (id_src),
    .ent_vld (vld_q),
    .ent_wb  (wb_q),
    .ent_ld  (ld_q),
    .ent_dst (dst_q),
    .hit     (hit),
    .k       (k),
    .ready   (ready),
    .early   (early)
  );

  // Per-source select and stall; with forwarding off, any pre-WB match stalls
  // and WB is trusted to write through the register file.
  always_comb begin
    stall_src = '0;
    sel       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      stall_src[i] = en_forwarding ? (hit[i] && !ready[i]) : early[i];
      sel[i]       = (en_forwarding && hit[i] && ready[i])
                   ? SEL_W'(forw_sel_stage(int'(k[i])))
                   : SEL_W'(FORW_SEL_RF);
    end
    stall = (|stall_src) && id_valid && !flush;
  end

  assign sel_src     = sel;
  assign stall_count = cnt_q;

  // Advance the scoreboard unless frozen; stalled, flushed or invalid ID
  // instructions enter EXE as bubbles.
  always_comb begin
    vld_d = vld_q;
    wb_d  = wb_q;
    ld_d  = ld_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    if (!freeze) begin
      for (int j = DEPTH - 1; j > 0; j--) begin
        vld_d[j] = vld_q[j-1];
        wb_d[j]  = wb_q[j-1];
        ld_d[j]  = ld_q[j-1];
        dst_d[j] = dst_q[j-1];
      end
      vld_d[0] = id_valid && !stall && !flush;
      wb_d[0]  = id_wb_en;
      ld_d[0]  = id_is_load;
      dst_d[0] = id_dst;
      if (stall && cnt_q != '1) cnt_d = cnt_q + 32'd1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      wb_q  <= '0;
      ld_q  <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      wb_q  <= wb_d;
      ld_q  <= ld_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed, table-driven bench for fwd_scoreboard with default parameters.
module tb_fwd_scoreboard;
  import fwd_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en_forwarding, freeze, flush, id_valid, id_wb_en, id_is_load;
  logic [3:0]  id_dst;
  logic [11:0] id_src;
  logic [2:0]  id_src_used;
  logic [5:0]  sel_src;
  logic        stall;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .clk(clk), .rst(rst), .en_forwarding(en_forwarding), .freeze(freeze),
    .flush(flush), .id_valid(id_valid), .id_wb_en(id_wb_en),
    .id_is_load(id_is_load), .id_dst(id_dst), .id_src(id_src),
    .id_src_used(id_src_used), .sel_src(sel_src), .stall(stall),
    .stall_count(stall_count)
  );

  typedef struct {
    logic        rst, en, frz, fl, vld, wb, ld;
    logic [3:0]  dst;
    logic [11:0] src;
    logic [2:0]  used;
    logic [5:0]  esel;
    logic        estall;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [1:0] MEM = FORW_SEL_FROM_MEM;
  localparam logic [1:0] WB  = FORW_SEL_FROM_WB;

  function automatic logic [11:0] srcs(input int s2, input int s1, input int s0);
    return {4'(s2), 4'(s1), 4'(s0)};
  endfunction

  function automatic logic [5:0] sels(input logic [1:0] s2, input logic [1:0] s1,
                                      input logic [1:0] s0);
    return {s2, s1, s0};
  endfunction

  task automatic add(input logic r, en, frz, fl, vld, wb, ld, input int dst,
                     input logic [11:0] src, input logic [2:0] used,
                     input logic [5:0] esel, input logic estall, input int ecnt);
    vec_t v;
    v.rst = r; v.en = en; v.frz = frz; v.fl = fl; v.vld = vld; v.wb = wb; v.ld = ld;
    v.dst = 4'(dst); v.src = src; v.used = used;
    v.esel = esel; v.estall = estall; v.ecnt = 32'(ecnt);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int step, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, step, got, want);
    end
  endtask

  // Drive one cycle's inputs mid-cycle, then check the combinational outputs
  // and counter before the next rising edge commits the update.
  task automatic apply(input vec_t v, input int step);
    @(negedge clk);
    rst = v.rst; en_forwarding = v.en; freeze = v.frz; flush = v.fl;
    id_valid = v.vld; id_wb_en = v.wb; id_is_load = v.ld; id_dst = v.dst;
    id_src = v.src; id_src_used = v.used;
    #1;
    check("sel_src", step, 32'(sel_src), 32'(v.esel));
    check("stall", step, 32'(stall), 32'(v.estall));
    check("stall_count", step, stall_count, v.ecnt);
  endtask

  initial begin
    rst = 1'b1; en_forwarding = 1'b1; freeze = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_wb_en = 1'b0; id_is_load = 1'b0; id_dst = '0;
    id_src = '0; id_src_used = '0;
    repeat (2) @(posedge clk);

    //  rst en frz fl vld wb ld dst  src              used    esel                stall cnt
    // reset state, sources 1/2/3
    add(0, 1, 0, 0, 1, 0, 0, 0, srcs(3, 2, 1), 3'b111, sels(0, 0, 0),     0, 0);
    // ALU writes R5, then a reader: one stall, then forward from k=1
    add(0, 1, 0, 0, 1, 1, 0, 5, srcs(3, 2, 1), 3'b111, sels(0, 0, 0),     0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, srcs(2, 1, 5), 3'b111, sels(0, 0, 0),     1, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, srcs(2, 1, 5), 3'b111, sels(0, 0, MEM),   0, 1);
    // LDR R4 then ADD R8 <- R4: two stalls then WB forward
    add(0, 1, 0, 0, 1, 1, 1, 4, srcs(0, 0, 0), 3'b000, sels(0, 0, 0),     0, 1);
    add(0, 1, 0, 0, 1, 1, 0, 8, srcs(6, 6, 4), 3'b111, sels(0, 0, 0),     1, 1);
    add(0, 1, 0, 0, 1, 1, 0, 8, srcs(6, 6, 4), 3'b111, sels(0, 0, 0),     1, 2);
    add(0, 1, 0, 0, 1, 1, 0, 8, srcs(6, 6, 4), 3'b111, sels(0, 0, WB),    0, 3);
    // same load-use with freeze held 3 cycles mid-stall
    add(0, 1, 0, 0, 1, 1, 1, 4, srcs(0, 0, 0), 3'b000, sels(0, 0, 0),     0, 3);
    add(0, 1, 0, 0, 1, 1, 0, 8, srcs(6, 6, 4), 3'b111, sels(0, 0, 0),     1, 3);
    add(0, 1, 1, 0, 1, 1, 0, 8, srcs(6, 6, 4), 3'b111, sels(0, 0, 0),     1, 4);
    add(0, 1, 1, 0, 1, 1, 0, 8, srcs(6, 6, 4), 3'b111, sels(0, 0, 0),     1, 4);
    add(0, 1, 1, 0, 1, 1, 0, 8, srcs(6, 6, 4), 3'b111, sels(0, 0, 0),     1, 4);
    add(0, 1, 0, 0, 1, 1, 0, 8, srcs(6, 6, 4), 3'b111, sels(0, 0, 0),     1, 4);
    add(0, 1, 0, 0, 1, 1, 0, 8, srcs(6, 6, 4), 3'b111, sels(0, 0, WB),    0, 5);
    // two writers of R7; youngest (k=1) wins, then drop src0 usage
    add(0, 1, 0, 0, 1, 1, 0, 7, srcs(0, 0, 0), 3'b000, sels(0, 0, 0),     0, 5);
    add(0, 1, 0, 0, 1, 1, 0, 7, srcs(0, 0, 0), 3'b000, sels(0, 0, 0),     0, 5);
    add(0, 1, 0, 0, 1, 0, 0, 0, srcs(0, 0, 0), 3'b000, sels(0, 0, 0),     0, 5);
    add(0, 1, 1, 0, 1, 0, 0, 0, srcs(7, 3, 7), 3'b111, sels(MEM, 0, MEM), 0, 5);
    add(0, 1, 1, 0, 1, 0, 0, 0, srcs(7, 3, 7), 3'b110, sels(MEM, 0, 0),   0, 5);
    // forwarding disabled: k=1 match stalls, WB-only match does not
    add(0, 0, 0, 0, 1, 0, 0, 0, srcs(7, 3, 7), 3'b111, sels(0, 0, 0),     1, 5);
    add(0, 0, 0, 0, 1, 0, 0, 0, srcs(7, 3, 7), 3'b111, sels(0, 0, 0),     0, 6);
    // flush over a hazard: no stall, flushed writer of R10 never enters
    add(0, 1, 0, 0, 1, 1, 0, 9, srcs(0, 0, 0), 3'b000, sels(0, 0, 0),     0, 6);
    add(0, 1, 0, 1, 1, 1, 0,10, srcs(0, 0, 9), 3'b001, sels(0, 0, 0),     0, 6);
    add(0, 1, 0, 0, 1, 0, 0, 0, srcs(0, 9,10), 3'b011, sels(0, MEM, 0),   0, 6);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Hand sequence: reset asserted during a load-use stall.
    begin
      vec_t v;
      v = '{rst:0, en:1, frz:0, fl:0, vld:1, wb:1, ld:1, dst:4'd11,
            src:srcs(0, 0, 0), used:3'b000, esel:6'd0, estall:0, ecnt:32'd6};
      apply(v, 100);
      v.wb = 0; v.ld = 0; v.dst = 0; v.src = srcs(11, 11, 11); v.used = 3'b111;
      v.estall = 1;
      apply(v, 101);                         // k=0 load: stall
      v.rst = 1; v.ecnt = 32'd7;
      apply(v, 102);                         // k=1 load: still stalled, reset here
      v.rst = 0; v.estall = 0; v.ecnt = 32'd0;
      apply(v, 103);                         // scoreboard empty, counter cleared
      apply(v, 104);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
